// File: rtl/down_counter_pkg.sv
// -----------------------------------------------------------------------------
// down_counter_pkg: shared types and constants for the loadable down-counter.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package down_counter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    EXPIRE = 2'd2
  } state_e;

  localparam int unsigned C_DEFAULT_WIDTH = 4;

endpackage : down_counter_pkg

`default_nettype wire

// File: rtl/down_counter.sv
// -----------------------------------------------------------------------------
// down_counter: loadable down-counter/timer with terminal-count pulse and
// optional auto-reload for periodic ticks.  Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module down_counter
  import down_counter_pkg::*;
#(
  parameter int unsigned WIDTH = C_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             auto_reload,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc
);

  localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      count_q  <= '1;
      reload_q <= '1;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;

    if (load) begin
      reload_d = load_val;
      count_d  = load_val;
      state_d  = (load_val != '0) ? RUN : EXPIRE;
    end else if (stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: ;
        RUN: begin
          if (en) begin
            // Saturate at zero: the final step lands on 0 and enters EXPIRE.
            if (count_q > C_ONE) begin
              count_d = count_q - C_ONE;
            end else begin
              count_d = '0;
              state_d = EXPIRE;
            end
          end
        end
        EXPIRE: begin
          if (auto_reload) begin
            count_d = reload_q;
            state_d = (reload_q != '0) ? RUN : EXPIRE;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign count = count_q;
  assign busy  = (state_q != IDLE);
  assign tc    = (state_q == EXPIRE);

endmodule : down_counter

`default_nettype wire

// File: tb/tb_down_counter.sv
// -----------------------------------------------------------------------------
// tb_down_counter: table-driven directed bench for down_counter (WIDTH=4).
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_down_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       load;
  logic [3:0] load_val;
  logic       auto_reload;
  logic       stop;
  logic [3:0] count;
  logic       busy;
  logic       tc;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       load;
    logic [3:0] load_val;
    logic       en;
    logic       ar;
    logic       stop;
    logic [3:0] exp_count;
    logic       exp_busy;
    logic       exp_tc;
    string      name;
  } vec_t;

  vec_t vecs[$];

  down_counter #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .load        (load),
    .load_val    (load_val),
    .auto_reload (auto_reload),
    .stop        (stop),
    .count       (count),
    .busy        (busy),
    .tc          (tc)
  );

  // Clock starts late so the initial reset window has no clock edge.
  initial begin
    clk = 1'b0;
    #20;
    forever #5 clk = ~clk;
  end

  task automatic add(input logic ld, input logic [3:0] lv, input logic e,
                     input logic a, input logic s, input logic [3:0] c,
                     input logic b, input logic t, input string n);
    vec_t v;
    v.load = ld; v.load_val = lv; v.en = e; v.ar = a; v.stop = s;
    v.exp_count = c; v.exp_busy = b; v.exp_tc = t; v.name = n;
    vecs.push_back(v);
  endtask

  task automatic check(input string n, input logic [3:0] c, input logic b,
                       input logic t);
    checks++;
    if (count !== c || busy !== b || tc !== t) begin
      errors++;
      $display("FAIL %s: got count=%0d busy=%0b tc=%0b, expected count=%0d busy=%0b tc=%0b",
               n, count, busy, tc, c, b, t);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; load_val = 4'd0;
    auto_reload = 1'b0; stop = 1'b0;

    //        ld lv  en ar st  cnt busy tc
    // one-shot
    add(1, 4'd5, 1, 0, 0, 4'd5, 1, 0, "os_load5");
    add(0, 4'd0, 1, 0, 0, 4'd4, 1, 0, "os_4");
    add(0, 4'd0, 1, 0, 0, 4'd3, 1, 0, "os_3");
    add(0, 4'd0, 1, 0, 0, 4'd2, 1, 0, "os_2");
    add(0, 4'd0, 1, 0, 0, 4'd1, 1, 0, "os_1");
    add(0, 4'd0, 1, 0, 0, 4'd0, 1, 1, "os_tc");
    for (int i = 0; i < 6; i++) add(0, 4'd0, 1, 0, 0, 4'd0, 0, 0, "os_idle_hold");
    // periodic
    add(1, 4'd3, 1, 1, 0, 4'd3, 1, 0, "per_load3");
    add(0, 4'd0, 1, 1, 0, 4'd2, 1, 0, "per_2");
    add(0, 4'd0, 1, 1, 0, 4'd1, 1, 0, "per_1");
    add(0, 4'd0, 1, 1, 0, 4'd0, 1, 1, "per_tc1");
    add(0, 4'd0, 1, 1, 0, 4'd3, 1, 0, "per_reload");
    add(0, 4'd0, 1, 1, 0, 4'd2, 1, 0, "per_2b");
    add(0, 4'd0, 1, 1, 0, 4'd1, 1, 0, "per_1b");
    add(0, 4'd0, 1, 1, 0, 4'd0, 1, 1, "per_tc2");
    add(0, 4'd0, 1, 1, 0, 4'd3, 1, 0, "per_reload2");
    add(0, 4'd0, 1, 1, 0, 4'd2, 1, 0, "per_2c");
    add(0, 4'd0, 1, 1, 0, 4'd1, 1, 0, "per_1c");
    add(0, 4'd0, 1, 1, 0, 4'd0, 1, 1, "per_tc3");
    // load in EXPIRE overrides auto-reload
    add(1, 4'd2, 1, 1, 0, 4'd2, 1, 0, "ovr_load2_in_expire");
    add(0, 4'd0, 1, 1, 0, 4'd1, 1, 0, "ovr_1");
    add(0, 4'd0, 1, 1, 0, 4'd0, 1, 1, "ovr_tc");
    add(0, 4'd0, 1, 1, 0, 4'd2, 1, 0, "ovr_new_reload");
    add(0, 4'd0, 1, 1, 1, 4'd2, 0, 0, "stop_at2");
    // reload value zero with auto-reload keeps tc high
    add(1, 4'd0, 0, 1, 0, 4'd0, 1, 1, "zero_ar_load");
    add(0, 4'd0, 0, 1, 0, 4'd0, 1, 1, "zero_ar_hold1");
    add(0, 4'd0, 0, 1, 0, 4'd0, 1, 1, "zero_ar_hold2");
    add(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, "zero_ar_release");
    // load 0 one-shot
    add(1, 4'd0, 0, 0, 0, 4'd0, 1, 1, "load0_tc");
    add(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, "load0_idle");
    // enable gating
    add(1, 4'd4, 1, 0, 0, 4'd4, 1, 0, "gate_load4");
    add(0, 4'd0, 1, 0, 0, 4'd3, 1, 0, "gate_3");
    add(0, 4'd0, 1, 0, 0, 4'd2, 1, 0, "gate_2");
    add(0, 4'd0, 0, 0, 0, 4'd2, 1, 0, "gate_hold_a");
    add(0, 4'd0, 0, 0, 0, 4'd2, 1, 0, "gate_hold_b");
    add(0, 4'd0, 1, 0, 0, 4'd1, 1, 0, "gate_1");
    add(0, 4'd0, 1, 0, 0, 4'd0, 1, 1, "gate_tc");
    add(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, "gate_en0_expire_ends");
    // load 9 in RUN at count 3
    add(1, 4'd5, 1, 0, 0, 4'd5, 1, 0, "rl_load5");
    add(0, 4'd0, 1, 0, 0, 4'd4, 1, 0, "rl_4");
    add(0, 4'd0, 1, 0, 0, 4'd3, 1, 0, "rl_3");
    add(1, 4'd9, 1, 0, 0, 4'd9, 1, 0, "rl_load9");
    add(0, 4'd0, 1, 0, 0, 4'd8, 1, 0, "rl_8");
    // stop at 6, then stop+load together
    add(0, 4'd0, 1, 0, 0, 4'd7, 1, 0, "st_7");
    add(0, 4'd0, 1, 0, 0, 4'd6, 1, 0, "st_6");
    add(0, 4'd0, 1, 0, 1, 4'd6, 0, 0, "st_stop6");
    add(0, 4'd0, 1, 1, 0, 4'd6, 0, 0, "st_idle_ignores_en");
    add(1, 4'd8, 1, 0, 1, 4'd8, 1, 0, "st_stop_and_load8");
    add(0, 4'd0, 1, 0, 0, 4'd7, 1, 0, "st_7b");

    // asynchronous reset with no clock edge
    #1 rst = 1'b0;
    #2 check("reset_async_assert", 4'd15, 1'b0, 1'b0);
    #7 check("reset_hold_10ns", 4'd15, 1'b0, 1'b0);
    #5 rst = 1'b1;

    foreach (vecs[i]) begin
      load = vecs[i].load; load_val = vecs[i].load_val; en = vecs[i].en;
      auto_reload = vecs[i].ar; stop = vecs[i].stop;
      step();
      check(vecs[i].name, vecs[i].exp_count, vecs[i].exp_busy, vecs[i].exp_tc);
    end

    // mid-RUN asynchronous reset at count 7
    load = 1'b1; load_val = 4'd7; en = 1'b1; auto_reload = 1'b0; stop = 1'b0;
    step();
    load = 1'b0; en = 1'b0;
    check("mr_load7", 4'd7, 1'b1, 1'b0);
    #2 rst = 1'b0;
    #1 check("mr_async_reset", 4'd15, 1'b0, 1'b0);
    #1 rst = 1'b1;
    en = 1'b1;
    step();
    check("mr_idle_after_reset", 4'd15, 1'b0, 1'b0);
    // auto-reload without load after reset: counts never start from IDLE
    auto_reload = 1'b1;
    step();
    check("mr_idle_ignores_ar", 4'd15, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_down_counter

`default_nettype wire
